pe_array_group: RTL and testbench

PE_ARRAY_GROUP -- requirements
Module: pe_array_group

---
 rtl/pe_pkg.sv | 40 ++++
 rtl/pe_mac_row.sv | 53 +++++
 rtl/pe_array_group.sv | 206 ++++++++++++++++++++
 tb/tb_pe_array_group.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE array group.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pe_pkg;

  // Transaction phases of the array group controller.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_O  = 3'd1,
    LOAD_W  = 3'd2,
    LOAD_I  = 3'd3,
    COMPUTE = 3'd4,
    DRAIN   = 3'd5
  } peState_t;

  // The widest data word supported; the MAC result is carried at this
  // precision so one non-parameterised helper can clamp any width.
  localparam int MaxDataWidth = 64;
  localparam int AccWidth     = 2 * MaxDataWidth + 2;
  typedef logic signed [AccWidth-1:0] acc_t;

  // Index width for a register file of n entries (at least one bit).
  function automatic int addrWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Saturating mode clamps to the signed range of 'width' bits. Wrap mode
  // returns the exact value; the caller keeps only the low 'width' bits.
  function automatic acc_t fitResult(input acc_t x, input int width, input logic sat);
    acc_t maxV;
    acc_t minV;
    maxV = (acc_t'(1) <<< (width - 1)) - acc_t'(1);
    minV = -maxV - acc_t'(1);
    if (!sat)      return x;
    if (x > maxV)  return maxV;
    if (x < minV)  return minV;
    return x;
  endfunction

endpackage

// File: rtl/pe_mac_row.sv
// One output-channel row: psum register plus multiply-accumulate with wrap/clamp.
// Latency: psum updates one cycle after loadEn or macEn.
// Backpressure: none; the controller decides when to load or accumulate.
// Ports: clk/aclr clock and async active-low reset; loadEn/loadData write an
// initial partial sum; macEn/wData/iData accumulate one product; psum is the
// registered accumulator.
module pe_mac_row
  import pe_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter bit Saturate  = 1'b0
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 loadEn,
  input  logic [DataWidth-1:0] loadData,
  input  logic                 macEn,
  input  logic [DataWidth-1:0] wData,
  input  logic [DataWidth-1:0] iData,
  output logic [DataWidth-1:0] psum
);

  localparam int ProdW = 2 * DataWidth;
  localparam int SumW  = ProdW + 1;

  logic signed [ProdW-1:0] wExt;
  logic signed [ProdW-1:0] iExt;
  logic signed [ProdW-1:0] prod;
  logic signed [SumW-1:0]  sum;
  acc_t                    sumWide;
  logic [DataWidth-1:0]    psumNext;

  // Full-precision product and sum; nothing is lost before the fit step.
  always_comb begin
    wExt     = {{DataWidth{wData[DataWidth-1]}}, wData};
    iExt     = {{DataWidth{iData[DataWidth-1]}}, iData};
    prod     = wExt * iExt;
    sum      = {prod[ProdW-1], prod} + {{(DataWidth + 1){psum[DataWidth-1]}}, psum};
    sumWide  = {{(AccWidth - SumW){sum[SumW-1]}}, sum};
    psumNext = DataWidth'(fitResult(sumWide, DataWidth, Saturate));
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      psum <= '0;
    end else if (loadEn) begin
      psum <= loadData;
    end else if (macEn) begin
      psum <= psumNext;
    end
  end

endmodule

// File: rtl/pe_array_group.sv
// PE array group: loads partial sums, then per block weights and activations, runs a sliding MAC, drains results.
// Latency: O + B*(W + (O+W-1) + W) + O cycles per transaction with all streams valid and ready.
// Backpressure: each input Rdy is high only in its load state; DRAIN holds data and valid while O_DataOutRdy is low.
// Ports: clk/aclr clock and async active-low reset; W_*, I_*, O_DataIn* are
// valid/ready input streams (weights, activations, initial psums); O_DataOut*
// is the result stream; Cfg_Blocks is sampled with the first psum beat; Busy
// is high outside IDLE.
module pe_array_group
  import pe_pkg::*;
#(
  parameter int DataWidth       = 32,
  parameter int O_PEGroupSize   = 4,
  parameter int W_PEGroupSize   = 4,
  parameter int BlockCountWidth = 4,
  parameter int Saturate        = 0
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       W_DataInValid,
  output logic                       W_DataInRdy,
  input  logic [DataWidth-1:0]       W_DataIn,
  input  logic                       I_DataInValid,
  output logic                       I_DataInRdy,
  input  logic [DataWidth-1:0]       I_DataIn,
  input  logic                       O_DataInValid,
  output logic                       O_DataInRdy,
  input  logic [DataWidth-1:0]       O_DataIn,
  output logic                       O_DataOutValid,
  input  logic                       O_DataOutRdy,
  output logic [DataWidth-1:0]       O_DataOut,
  input  logic [BlockCountWidth-1:0] Cfg_Blocks,
  output logic                       Busy
);

  localparam int ICount = O_PEGroupSize + W_PEGroupSize - 1;
  localparam int OAddrW = addrWidth(O_PEGroupSize);
  localparam int WAddrW = addrWidth(W_PEGroupSize);
  // One shared beat/cycle counter; the activation file is the longest phase.
  localparam int CntW   = addrWidth(ICount);

  localparam logic [CntW-1:0] OLast = CntW'(O_PEGroupSize - 1);
  localparam logic [CntW-1:0] WLast = CntW'(W_PEGroupSize - 1);
  localparam logic [CntW-1:0] ILast = CntW'(ICount - 1);

  peState_t                   state, stateNext;
  logic [CntW-1:0]            cnt, cntNext;
  logic [BlockCountWidth-1:0] blkCnt, blkCntNext;
  logic [BlockCountWidth-1:0] blkTotal, blkTotalNext;
  logic                       macEn;

  logic [DataWidth-1:0] wReg [W_PEGroupSize];
  logic [DataWidth-1:0] iReg [ICount];
  logic [DataWidth-1:0] psum [O_PEGroupSize];

  logic              oFire, wFire, iFire, outFire;
  logic [OAddrW-1:0] oIdx;
  logic [WAddrW-1:0] wIdx;

  assign oFire   = O_DataInValid && O_DataInRdy;
  assign wFire   = W_DataInValid && W_DataInRdy;
  assign iFire   = I_DataInValid && I_DataInRdy;
  assign outFire = O_DataOutValid && O_DataOutRdy;

  // Row 0 is written from IDLE; later rows and the drain walk follow cnt.
  assign oIdx = (state == IDLE) ? '0 : cnt[OAddrW-1:0];
  assign wIdx = cnt[WAddrW-1:0];

  assign Busy      = (state != IDLE);
  assign O_DataOut = (state == DRAIN) ? psum[oIdx] : '0;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state    <= IDLE;
      cnt      <= '0;
      blkCnt   <= '0;
      blkTotal <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      blkCnt   <= blkCntNext;
      blkTotal <= blkTotalNext;
    end
  end

  always_comb begin
    stateNext      = state;
    cntNext        = cnt;
    blkCntNext     = blkCnt;
    blkTotalNext   = blkTotal;
    O_DataInRdy    = 1'b0;
    W_DataInRdy    = 1'b0;
    I_DataInRdy    = 1'b0;
    O_DataOutValid = 1'b0;
    macEn          = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so nothing looks acceptable while aclr is low.
        O_DataInRdy = aclr;
        if (O_DataInValid && aclr) begin
          blkCntNext   = '0;
          blkTotalNext = (Cfg_Blocks == '0) ? BlockCountWidth'(1) : Cfg_Blocks;
          if (O_PEGroupSize == 1) begin
            stateNext = LOAD_W;
            cntNext   = '0;
          end else begin
            stateNext = LOAD_O;
            cntNext   = CntW'(1);
          end
        end
      end
      LOAD_O: begin
        O_DataInRdy = 1'b1;
        if (O_DataInValid) begin
          if (cnt == OLast) begin
            stateNext = LOAD_W;
            cntNext   = '0;
          end else begin
            cntNext = cnt + CntW'(1);
          end
        end
      end
      LOAD_W: begin
        W_DataInRdy = 1'b1;
        if (W_DataInValid) begin
          if (cnt == WLast) begin
            stateNext = LOAD_I;
            cntNext   = '0;
          end else begin
            cntNext = cnt + CntW'(1);
          end
        end
      end
      LOAD_I: begin
        I_DataInRdy = 1'b1;
        if (I_DataInValid) begin
          if (cnt == ILast) begin
            stateNext = COMPUTE;
            cntNext   = '0;
          end else begin
            cntNext = cnt + CntW'(1);
          end
        end
      end
      COMPUTE: begin
        macEn = 1'b1;
        if (cnt == WLast) begin
          cntNext = '0;
          if (blkCnt == blkTotal - BlockCountWidth'(1)) begin
            stateNext = DRAIN;
          end else begin
            stateNext  = LOAD_W;
            blkCntNext = blkCnt + BlockCountWidth'(1);
          end
        end else begin
          cntNext = cnt + CntW'(1);
        end
      end
      DRAIN: begin
        O_DataOutValid = 1'b1;
        if (O_DataOutRdy) begin
          if (cnt == OLast) begin
            stateNext = IDLE;
            cntNext   = '0;
          end else begin
            cntNext = cnt + CntW'(1);
          end
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int k = 0; k < W_PEGroupSize; k++) wReg[k] <= '0;
      for (int k = 0; k < ICount; k++)        iReg[k] <= '0;
    end else begin
      if (wFire) wReg[wIdx] <= W_DataIn;
      if (iFire) iReg[cnt]  <= I_DataIn;
    end
  end

  // Row r sees weight tap cnt and activation r+cnt: a sliding window.
  for (genvar r = 0; r < O_PEGroupSize; r++) begin : gRow
    logic [CntW-1:0] iIdx;
    assign iIdx = cnt + CntW'(r);

    pe_mac_row #(
      .DataWidth(DataWidth),
      .Saturate (Saturate != 0)
    ) uRow (
      .clk     (clk),
      .aclr    (aclr),
      .loadEn  (oFire && (oIdx == OAddrW'(r))),
      .loadData(O_DataIn),
      .macEn   (macEn),
      .wData   (wReg[wIdx]),
      .iData   (iReg[iIdx]),
      .psum    (psum[r])
    );
  end

endmodule

// File: tb/tb_pe_array_group.sv
// Bench for pe_array_group: queue-driven streams, reference model, output scoreboard.
// Latency: checks full-throughput transaction length.
// Backpressure: random and directed stalls on the result stream.
module tb_pe_array_group;
  localparam int O  = 4;
  localparam int W  = 4;
  localparam int NI = O + W - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aclr;
  logic        W_DataInValid, W_DataInRdy, I_DataInValid, I_DataInRdy;
  logic        O_DataInValid, O_DataInRdy, O_DataOutValid, O_DataOutRdy, Busy;
  logic [31:0] W_DataIn, I_DataIn, O_DataIn, O_DataOut;
  logic [3:0]  Cfg_Blocks;

  pe_array_group dut (
    .clk(clk), .aclr(aclr),
    .W_DataInValid(W_DataInValid), .W_DataInRdy(W_DataInRdy), .W_DataIn(W_DataIn),
    .I_DataInValid(I_DataInValid), .I_DataInRdy(I_DataInRdy), .I_DataIn(I_DataIn),
    .O_DataInValid(O_DataInValid), .O_DataInRdy(O_DataInRdy), .O_DataIn(O_DataIn),
    .O_DataOutValid(O_DataOutValid), .O_DataOutRdy(O_DataOutRdy), .O_DataOut(O_DataOut),
    .Cfg_Blocks(Cfg_Blocks), .Busy(Busy)
  );

  // Two 8-bit instances fed identical all-127 streams, differing only in fit mode.
  logic       vld8;
  logic [7:0] v127 = 8'd127;
  logic [7:0] zero8 = 8'd0;
  logic [3:0] one4 = 4'd1;
  logic       satWRdy, satIRdy, satORdy, satVld, satBusy;
  logic       wrpWRdy, wrpIRdy, wrpORdy, wrpVld, wrpBusy;
  logic [7:0] satOut, wrpOut;

  pe_array_group #(.DataWidth(8), .Saturate(1)) dutSat (
    .clk(clk), .aclr(aclr),
    .W_DataInValid(vld8), .W_DataInRdy(satWRdy), .W_DataIn(v127),
    .I_DataInValid(vld8), .I_DataInRdy(satIRdy), .I_DataIn(v127),
    .O_DataInValid(vld8), .O_DataInRdy(satORdy), .O_DataIn(zero8),
    .O_DataOutValid(satVld), .O_DataOutRdy(1'b1), .O_DataOut(satOut),
    .Cfg_Blocks(one4), .Busy(satBusy)
  );

  pe_array_group #(.DataWidth(8), .Saturate(0)) dutWrap (
    .clk(clk), .aclr(aclr),
    .W_DataInValid(vld8), .W_DataInRdy(wrpWRdy), .W_DataIn(v127),
    .I_DataInValid(vld8), .I_DataInRdy(wrpIRdy), .I_DataIn(v127),
    .O_DataInValid(vld8), .O_DataInRdy(wrpORdy), .O_DataIn(zero8),
    .O_DataOutValid(wrpVld), .O_DataOutRdy(1'b1), .O_DataOut(wrpOut),
    .Cfg_Blocks(one4), .Busy(wrpBusy)
  );

  int errors = 0;
  int checks = 0;

  int          tP [O];
  int          tW [16][W];
  int          tI [16][NI];
  int unsigned lastExp [O];

  int unsigned wQ[$], iQ[$], oQ[$], expQ[$], obsQ[$], satQ[$], wrpQ[$];
  bit randGap = 0;
  bit randRdy = 0;
  int stallLeft = 0;
  int busyCyc = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: each row adds sum over blocks and taps of W[b][c]*I[b][r+c]
  // to its initial value; wrap means the result is the total mod 2^32.
  task automatic buildExpected(input int blocks);
    longint acc [O];
    int nb;
    nb = (blocks == 0) ? 1 : blocks;
    for (int r = 0; r < O; r++) acc[r] = longint'(tP[r]);
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < W; c++)
        for (int r = 0; r < O; r++)
          acc[r] += longint'(tW[b][c]) * longint'(tI[b][r + c]);
    for (int r = 0; r < O; r++) lastExp[r] = acc[r][31:0];
  endtask

  task automatic fillBasic(input int p0);
    for (int r = 0; r < O; r++) tP[r] = p0;
    for (int c = 0; c < W; c++) tW[0][c] = 1;
    for (int k = 0; k < NI; k++) tI[0][k] = k + 1;
  endtask

  task automatic startTxn(input int blocks, input bit wFirst);
    int nb;
    int n;
    obsQ.delete();
    busyCyc = 0;
    buildExpected(blocks);
    for (int r = 0; r < O; r++) expQ.push_back(lastExp[r]);
    nb = (blocks == 0) ? 1 : blocks;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < W; c++)  wQ.push_back(tW[b][c]);
      for (int k = 0; k < NI; k++) iQ.push_back(tI[b][k]);
    end
    Cfg_Blocks = 4'(blocks);
    if (wFirst) begin
      repeat (3) @(negedge clk);
      #2;
      check("idle_w_rdy", W_DataInRdy, 0);
      check("idle_w_vld", W_DataInValid, 1);
      check("idle_w_held", wQ.size(), nb * W - 1);
    end
    for (int r = 0; r < O; r++) oQ.push_back(tP[r]);
    n = 0;
    while (!Busy && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("busy_start", Busy, 1);
    // Latched already; later changes must not matter.
    Cfg_Blocks = 4'($urandom);
  endtask

  task automatic finishTxn();
    int n;
    n = 0;
    while ((expQ.size() != 0 || Busy) && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("txn_done", (expQ.size() == 0 && !Busy), 1);
    check("beats_left", wQ.size() + iQ.size() + oQ.size()
          + W_DataInValid + I_DataInValid + O_DataInValid, 0);
  endtask

  task automatic pin(input string tag, input int unsigned e0, input int unsigned e1,
                     input int unsigned e2, input int unsigned e3);
    int unsigned e [O];
    e = '{e0, e1, e2, e3};
    for (int r = 0; r < O; r++) check({tag, "_model"}, lastExp[r], e[r]);
    check({tag, "_count"}, obsQ.size(), O);
    if (obsQ.size() == O)
      for (int r = 0; r < O; r++) check({tag, "_out"}, obsQ[r], e[r]);
  endtask

  // Stream drivers: present queued beats, hold valid until the beat transfers.
  initial begin
    bit wF, iF, oF;
    W_DataInValid = 0; I_DataInValid = 0; O_DataInValid = 0;
    W_DataIn = 0; I_DataIn = 0; O_DataIn = 0;
    forever begin
      @(negedge clk);
      wF = W_DataInValid && W_DataInRdy;
      iF = I_DataInValid && I_DataInRdy;
      oF = O_DataInValid && O_DataInRdy;
      @(posedge clk);
      #1;
      if (wF) W_DataInValid = 0;
      if (iF) I_DataInValid = 0;
      if (oF) O_DataInValid = 0;
      if (!W_DataInValid && wQ.size() > 0 && (!randGap || $urandom_range(0, 3) != 0)) begin
        W_DataIn = wQ.pop_front(); W_DataInValid = 1;
      end
      if (!I_DataInValid && iQ.size() > 0 && (!randGap || $urandom_range(0, 3) != 0)) begin
        I_DataIn = iQ.pop_front(); I_DataInValid = 1;
      end
      if (!O_DataInValid && oQ.size() > 0 && (!randGap || $urandom_range(0, 3) != 0)) begin
        O_DataIn = oQ.pop_front(); O_DataInValid = 1;
      end
    end
  end

  initial begin
    O_DataOutRdy = 1;
    forever begin
      @(posedge clk);
      #1;
      if (stallLeft > 0 && obsQ.size() >= 1) begin
        O_DataOutRdy = 0;
        stallLeft--;
      end else begin
        O_DataOutRdy = randRdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  always @(negedge clk) if (Busy) busyCyc++;

  always @(negedge clk) begin
    if (satVld && satQ.size() < 8) satQ.push_back(int'(satOut));
    if (wrpVld && wrpQ.size() < 8) wrpQ.push_back(int'(wrpOut));
  end

  // Scoreboard: every transferred result against the model, and held data stable.
  initial begin
    bit          held;
    logic [31:0] heldVal;
    held = 0;
    heldVal = 0;
    forever begin
      @(negedge clk);
      if (aclr && O_DataOutValid) begin
        if (held) check("drain_stable", O_DataOut, heldVal);
        if (O_DataOutRdy) begin
          if (expQ.size() == 0) begin
            check("unexpected_out", O_DataOut, -1);
          end else begin
            check("result", O_DataOut, expQ.pop_front());
          end
          obsQ.push_back(O_DataOut);
          held = 0;
        end else begin
          held = 1;
          heldVal = O_DataOut;
        end
      end else begin
        if (held) check("valid_dropped", O_DataOutValid, 1);
        held = 0;
      end
    end
  end

  initial begin
    int n;
    aclr = 0;
    vld8 = 0;
    Cfg_Blocks = 4'd1;
    #1;
    check("rst_busy", Busy, 0);
    check("rst_ovld", O_DataOutValid, 0);
    check("rst_out", O_DataOut, 0);
    check("rst_ordy", O_DataInRdy, 0);
    check("rst_wrdy", W_DataInRdy, 0);
    check("rst_irdy", I_DataInRdy, 0);
    repeat (3) @(posedge clk);
    #1 aclr = 1;
    vld8 = 1;
    #1 check("idle_ordy", O_DataInRdy, 1);

    // Basic single block.
    fillBasic(0);
    startTxn(1, 0);
    finishTxn();
    pin("basic", 10, 14, 18, 22);
    check("basic_cycles", busyCyc, 22);

    // Zero block count behaves as one; W offered early is left alone.
    fillBasic(0);
    startTxn(0, 1);
    finishTxn();
    pin("zero_blk", 10, 14, 18, 22);
    check("zero_blk_cycles", busyCyc, 22);

    // Two blocks: second block adds 2*I[r] with I = 0..6.
    fillBasic(100);
    tW[1] = '{2, 0, 0, 0};
    for (int k = 0; k < NI; k++) tI[1][k] = k;
    startTxn(2, 0);
    finishTxn();
    pin("two_blk", 110, 116, 122, 128);
    check("two_blk_cycles", busyCyc, 4 + 2 * (4 + 7 + 4) + 4 - 1);

    // Result stream stalled for 5 cycles after the first beat.
    fillBasic(0);
    stallLeft = 5;
    startTxn(1, 0);
    n = 0;
    while (obsQ.size() < 1 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("stall_first", obsQ.size(), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2;
      check("stall_vld", O_DataOutValid, 1);
      check("stall_dat", O_DataOut, 14);
    end
    finishTxn();
    pin("stall", 10, 14, 18, 22);

    // Reset pulse in the middle of COMPUTE discards the transaction.
    fillBasic(0);
    startTxn(1, 0);
    n = 0;
    while (busyCyc < 16 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reach_compute", busyCyc >= 16, 1);
    @(posedge clk);
    #1 aclr = 0;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_ovld", O_DataOutValid, 0);
    check("mid_rst_out", O_DataOut, 0);
    check("mid_rst_ordy", O_DataInRdy, 0);
    check("mid_rst_wrdy", W_DataInRdy, 0);
    check("mid_rst_irdy", I_DataInRdy, 0);
    @(negedge clk);
    #2;
    wQ.delete(); iQ.delete(); oQ.delete(); expQ.delete();
    W_DataInValid = 0; I_DataInValid = 0; O_DataInValid = 0;
    @(posedge clk);
    #1 aclr = 1;
    #1;
    check("post_rst_ordy", O_DataInRdy, 1);
    check("post_rst_busy", Busy, 0);
    fillBasic(0);
    startTxn(1, 0);
    finishTxn();
    pin("post_rst", 10, 14, 18, 22);

    // Randomized transactions with input gaps and output backpressure.
    randGap = 1;
    randRdy = 1;
    for (int t = 0; t < 25; t++) begin
      for (int r = 0; r < O; r++) tP[r] = $urandom;
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < W; c++)  tW[b][c] = (t % 3 == 0) ? $urandom_range(0, 20) - 10 : $urandom;
        for (int k = 0; k < NI; k++) tI[b][k] = (t % 3 == 0) ? $urandom_range(0, 20) - 10 : $urandom;
      end
      startTxn($urandom_range(0, 3), t[0]);
      finishTxn();
    end

    // 8-bit pair: saturation pins at 127, wrap accumulates 16129 mod 256 = 1 per tap.
    check("sat_count", satQ.size() >= 4, 1);
    check("wrap_count", wrpQ.size() >= 4, 1);
    for (int r = 0; r < 4; r++) begin
      if (satQ.size() > r) check("sat_out", satQ[r], 127);
      if (wrpQ.size() > r) check("wrap_out", wrpQ[r], 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
